// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one full-subtractor cell.
// Optional signed-overflow flag enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             bit_d;
    logic             brw_nx;
    logic [WIDTH-1:0] res_nx;
    logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell operating on the current LSBs of the shift registers.
    always_comb begin
        bit_d    = a_sh[0] ^ b_sh[0] ^ brw;
        brw_nx   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
        res_nx   = {bit_d, res_sh[WIDTH-1:1]};
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else if (state == S_SHIFT) begin
            brw    <= brw_nx;
            res_sh <= res_nx;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                diff       <= res_nx;
                borrow_out <= brw_nx;
`ifdef SERIAL_SUB_OVF_EN
                ovf        <= (a_msb != b_msb) && (bit_d != a_msb);
`endif
                busy       <= 1'b0;
                done       <= 1'b1;
                state      <= S_DONE;
            end
        end else begin
            // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
            if (start) begin
                a_sh   <= a;
                b_sh   <= b;
                res_sh <= '0;
                brw    <= 1'b0;
                cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                a_msb  <= a[WIDTH-1];
                b_msb  <= b[WIDTH-1];
`endif
                busy   <= 1'b1;
                state  <= S_SHIFT;
            end
        end
    end

endmodule
